seg7_scan_driver: RTL and testbench

- Display-side consumer of the 7-bit count produced by the counter block.
- Accepts a binary value 0..127 on a load strobe and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Drives a 2-digit time-multiplexed 7-segment display (ones/tens) at a programmable refresh rate.
- Sits between the counter's state output and the board display pins.

---
 rtl/seg7_scan_driver_if.sv | 12 +
 rtl/seg7_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Value/strobe and display-pin bundle between the counter block and seg7_scan_driver.
interface seg7_scan_driver_if;
    logic [6:0] value;
    logic       load;
    logic       busy;
    logic       ovf;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (output value, load, input busy, ovf, seg, an);
    modport slave  (input value, load, output busy, ovf, seg, an);
endinterface

// File: rtl/seg7_scan_driver.sv
// Binary 0..127 to two-digit BCD (sequential double-dabble) driving a 2-digit multiplexed 7-seg display.
// Optional: define SEG7_BLANK_LEADING_ZERO_EN to blank the tens slot when the tens digit is 0.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic           clk,
    input  logic           xrst,
    seg7_scan_driver_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t           state_reg;
    logic [6:0]       bin_reg;
    logic [7:0]       bcd_reg;
    logic [2:0]       iter_reg;
    logic [3:0]       tens_reg;
    logic [3:0]       ones_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sel_reg;
    logic             busy_reg;
    logic             ovf_reg;
    logic [6:0]       seg_reg;
    logic [1:0]       an_reg;

    logic [7:0]       bcd_adj;
    logic             tick;
    logic [3:0]       digit_next;
    logic [6:0]       seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign tick       = (cnt_reg == CNT_W'(SCAN_DIV - 1));
    // sel_reg==1 now means the tick moves to ones; the pre-commit digits are used.
    assign digit_next = sel_reg ? ones_reg : tens_reg;

    always_comb begin
        seg_next = seg_decode(digit_next);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
        if (!sel_reg && tens_reg == 4'd0)
            seg_next = 7'h00;
`endif
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
            tens_reg  <= '0;
            ones_reg  <= '0;
            cnt_reg   <= '0;
            sel_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            seg_reg   <= 7'h00;
            an_reg    <= 2'b00;
        end else begin
            if (tick) begin
                cnt_reg <= '0;
                sel_reg <= ~sel_reg;
                an_reg  <= sel_reg ? 2'b01 : 2'b10;
                seg_reg <= seg_next;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (bus.load) begin
                        if (bus.value > 7'd99) begin
                            bin_reg <= 7'd99;
                            ovf_reg <= 1'b1;
                        end else begin
                            bin_reg <= bus.value;
                            ovf_reg <= 1'b0;
                        end
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= {bcd_adj[6:0], bin_reg, 1'b0};
                    iter_reg <= iter_reg + 3'd1;
                    if (iter_reg == 3'd6)
                        state_reg <= COMMIT;
                end
                COMMIT: begin
                    tens_reg  <= bcd_reg[7:4];
                    ones_reg  <= bcd_reg[3:0];
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.seg  = seg_reg;
    assign bus.an   = an_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Random + directed stimulus for seg7_scan_driver, checked every cycle against a cycle-count reference model.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 2;
    localparam logic [6:0] PAT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic clk  = 1'b0;
    logic xrst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: edges since reset, pending conversion and what the pins should show.
    int         e_cnt    = 0;
    bit         m_busy   = 0;
    int         commit_e = 0;
    int         p_tens   = 0;
    int         p_ones   = 0;
    int         m_tens   = 0;
    int         m_ones   = 0;
    bit         m_ovf    = 0;
    logic [6:0] m_seg    = 7'h00;
    logic [1:0] m_an     = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rs, input bit ld, input int v);
        bit busy_pre;
        int vv;
        if (!rs) begin
            e_cnt  = 0;
            m_busy = 0;
            m_ovf  = 0;
            m_seg  = 7'h00;
            m_an   = 2'b00;
            m_tens = 0;
            m_ones = 0;
        end else begin
            busy_pre = m_busy;
            e_cnt++;
            if (e_cnt % SCAN_DIV == 0) begin
                if ((e_cnt / SCAN_DIV) % 2 == 1) begin
                    m_an  = 2'b01;
                    m_seg = PAT[m_ones];
                end else begin
                    m_an  = 2'b10;
                    m_seg = PAT[m_tens];
`ifdef SEG7_BLANK_LEADING_ZERO_EN
                    if (m_tens == 0) m_seg = 7'h00;
`endif
                end
            end
            if (busy_pre && e_cnt == commit_e) begin
                m_tens = p_tens;
                m_ones = p_ones;
                m_busy = 0;
            end
            if (ld) begin
                if (!busy_pre) begin
                    vv       = (v > 99) ? 99 : v;
                    m_ovf    = (v > 99);
                    p_tens   = vv / 10;
                    p_ones   = vv % 10;
                    commit_e = e_cnt + 8;
                    m_busy   = 1;
                    $display("load value=%0d accepted -> tens=%0d ones=%0d ovf=%0d", v, p_tens, p_ones, m_ovf);
                end else begin
                    $display("load value=%0d ignored (busy)", v);
                end
            end
        end
    endtask

    task automatic step();
        bit rs, ld;
        int v;
        rs = xrst;
        ld = bus.load;
        v  = int'(bus.value);
        @(posedge clk);
        model_edge(rs, ld, v);
        #1;
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("ovf",  32'(bus.ovf),  32'(m_ovf));
        check("seg",  32'(bus.seg),  32'(m_seg));
        check("an",   32'(bus.an),   32'(m_an));
    endtask

    task automatic load_val(input int v);
        bus.value = 7'(v);
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        bus.value = 7'($urandom_range(0, 127));
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.value = 7'd0;
        xrst      = 1'b0;
        repeat (3) step();
        xrst = 1'b1;
        repeat (10) step();

        load_val(42);  repeat (14) step();
        load_val(120); repeat (14) step();
        load_val(5);   repeat (14) step();

        load_val(17);  repeat (2) step();
        load_val(63);  repeat (14) step();

        load_val(88);  repeat (4) step();
        xrst = 1'b0;   step();
        xrst = 1'b1;   repeat (10) step();

        load_val(99);  repeat (8) step();
        load_val(0);   repeat (14) step();

        for (int i = 0; i < 500; i++) begin
            xrst      = ($urandom_range(0, 79) != 0);
            bus.value = 7'($urandom_range(0, 127));
            bus.load  = ($urandom_range(0, 3) == 0);
            step();
        end
        bus.load = 1'b0;
        xrst     = 1'b1;
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
